// File: rtl/sub_word_mem_ctrl.sv
// Byte/half/word load-store controller in front of a word-wide memory.
// Sub-word stores use read-modify-write; every memory phase is bounded by TIMEOUT.
module sub_word_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  num_bits,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rd_data,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_DONE} state_t;

  state_t        state, nxt;
  logic          wr_q, sx_q, err_q;
  logic [1:0]    nb_q;
  logic [31:0]   addr_q, wd_q, rword_q, wword_q, rd_data_q;
  logic [CW-1:0] cnt_q;

  logic          illegal, timeout_hit;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val, merged;

  assign illegal = (num_bits == 2'd3) ||
                   (num_bits == 2'd1 && addr[0]) ||
                   (num_bits == 2'd2 && addr[1:0] != 2'b00);

  // Phase gives up on the TIMEOUT-th consecutive not-ready cycle.
  assign timeout_hit = !mem_ready && (cnt_q == CW'(TIMEOUT - 1));

  // Little-endian lane extraction for loads
  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (nb_q)
      2'd0:    load_val = {{24{sx_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_val = {{16{sx_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  // Overlay the store lane(s) onto the latched read word
  always_comb begin
    merged = rword_q;
    case (nb_q)
      2'd0: merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      2'd1: begin
        if (addr_q[1]) merged[31:16] = wd_q[15:0];
        else           merged[15:0]  = wd_q[15:0];
      end
      default: merged = rword_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (illegal)               nxt = S_DONE;
          else if (!wr)              nxt = S_RD;
          else if (num_bits == 2'd2) nxt = S_WR;
          else                       nxt = S_RD;
        end
      end
      S_RD: begin
        if (mem_ready)        nxt = wr_q ? S_MERGE : S_DONE;
        else if (timeout_hit) nxt = S_DONE;
      end
      S_MERGE: nxt = S_WR;
      S_WR: begin
        if (mem_ready || timeout_hit) nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      sx_q      <= 1'b0;
      nb_q      <= 2'd0;
      addr_q    <= '0;
      wd_q      <= '0;
      rword_q   <= '0;
      wword_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q   <= wr;
            sx_q   <= sign_ext;
            nb_q   <= num_bits;
            addr_q <= addr;
            wd_q   <= wr_data;
            err_q  <= illegal;
            cnt_q  <= '0;
            if (wr && num_bits == 2'd2) wword_q <= wr_data;
          end
        end
        S_RD: begin
          if (mem_ready) begin
            if (wr_q) rword_q   <= mem_rdata;
            else      rd_data_q <= load_val;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        S_MERGE: begin
          wword_q <= merged;
          cnt_q   <= '0;
        end
        S_WR: begin
          if (!mem_ready) begin
            cnt_q <= cnt_q + CW'(1);
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from the state register so reset clears them at once.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && err_q;
  assign mem_rd_en = (state == S_RD);
  assign mem_wr_en = (state == S_WR);
  assign mem_addr  = (state == S_RD || state == S_WR) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata = (state == S_WR) ? wword_q : 32'd0;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_sub_word_mem_ctrl.sv
// Directed vector bench for sub_word_mem_ctrl with a small word-memory model.
module tb_sub_word_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, wr = 1'b0, sign_ext = 1'b0;
  logic [1:0]  num_bits = 2'd0;
  logic [31:0] addr = '0, wr_data = '0;
  logic        busy, done, err, mem_rd_en, mem_wr_en, mem_ready;
  logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  logic        ready_en = 1'b1;
  logic [31:0] mem [0:15];
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [31:0] last_maddr = '0;
  int          nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  sub_word_mem_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .num_bits(num_bits),
    .sign_ext(sign_ext), .addr(addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .rd_data(rd_data), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  assign mem_ready = ready_en;
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      if (mem_ready) mem[mem_addr[5:2]] = mem_wdata;
    end
    if (mem_rd_en || mem_wr_en) last_maddr = mem_addr;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  nb;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    int          lat;
    logic        eerr;
    logic [31:0] exp_rd;
    logic [31:0] exp_mem;
    int          nrd;
    int          nwr;
  } vec_t;

  vec_t vt [12];

  // Issue one request, wait for Done (bounded) and check the outcome.
  task automatic run_vec(input vec_t v, input string tag);
    int   lat;
    bit   got;
    logic e_s;
    logic [31:0] r_s, a_exp;
    mem[v.addr[5:2]] = v.init;
    @(negedge clk);
    req = 1'b1; wr = v.wr; num_bits = v.nb; sign_ext = v.sx;
    addr = v.addr; wr_data = v.wdata;
    rd_cnt = 0; wr_cnt = 0;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; got = 1'b0; e_s = 1'b0; r_s = '0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (done) begin got = 1'b1; e_s = err; r_s = rd_data; end
    end
    if (!got) begin
      nchk++; nerr++;
      $display("FAIL %s_done: no Done within 40 cycles", tag);
      return;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_err"}, {31'd0, e_s}, {31'd0, v.eerr});
    chk({tag, "_rd"}, r_s, v.exp_rd);
    @(negedge clk);
    chk({tag, "_mem"}, mem[v.addr[5:2]], v.exp_mem);
    chk({tag, "_nrd"}, 32'(rd_cnt), 32'(v.nrd));
    chk({tag, "_nwr"}, 32'(wr_cnt), 32'(v.nwr));
    a_exp = {v.addr[31:2], 2'b00};
    if (v.nrd + v.nwr > 0) chk({tag, "_maddr"}, last_maddr, a_exp);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   dc0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    //        wr    nb    sx    addr          wdata         init          lat err  exp_rd        exp_mem       rd wr
    vt[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0,        32'h8899AABB, 2, 1'b0, 32'hFFFFFFAA, 32'h8899AABB, 1, 0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,        32'h8899AABB, 2, 1'b0, 32'h00000088, 32'h8899AABB, 1, 0};
    vt[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,        32'h8899AABB, 2, 1'b0, 32'hFFFF8899, 32'h8899AABB, 1, 0};
    vt[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0,        32'h8899AABB, 2, 1'b0, 32'h0000AABB, 32'h8899AABB, 1, 0};
    vt[4]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0010, 32'h0,        32'h8899AABB, 2, 1'b0, 32'h8899AABB, 32'h8899AABB, 1, 0};
    vt[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000BEEF, 32'h11223344, 4, 1'b0, 32'h8899AABB, 32'hBEEF3344, 1, 1};
    vt[6]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h12345678, 32'h11223344, 4, 1'b0, 32'h8899AABB, 32'h11227844, 1, 1};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'h11223344, 2, 1'b0, 32'h8899AABB, 32'hDEADBEEF, 0, 1};
    vt[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0013, 32'hDEADBEEF, 32'h11223344, 1, 1'b1, 32'h8899AABB, 32'h11223344, 0, 0};
    vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,        32'h11223344, 1, 1'b1, 32'h8899AABB, 32'h11223344, 0, 0};
    vt[10] = '{1'b0, 2'd1, 1'b1, 32'h0000_0011, 32'h0,        32'h11223344, 1, 1'b1, 32'h8899AABB, 32'h11223344, 0, 0};
    vt[11] = '{1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0,        32'h8899AA7F, 2, 1'b0, 32'h0000007F, 32'h8899AA7F, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rden", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_wren", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Timeout: load with memory never ready
    ready_en = 1'b0;
    v = '{1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'h0, 32'h12345678, 16, 1'b1, 32'h0000007F, 32'h12345678, 15, 0};
    run_vec(v, "tmo");
    ready_en = 1'b1;

    // Req while busy is ignored; one Done for the original load
    mem[4] = 32'h01020304;
    mem[5] = 32'h55555555;
    ready_en = 1'b0;
    dc0 = done_cnt;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; num_bits = 2'd2; sign_ext = 1'b0; addr = 32'h10; wr_data = '0;
    wr_cnt = 0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; num_bits = 2'd2; addr = 32'h14; wr_data = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    ready_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("bsy_ndone", 32'(done_cnt - dc0), 32'd1);
    chk("bsy_rd", rd_data, 32'h01020304);
    chk("bsy_nwr", 32'(wr_cnt), 32'd0);
    chk("bsy_mem5", mem[5], 32'h55555555);

    // Reset in the middle of a read phase
    ready_en = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; num_bits = 2'd2; addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rden_pre", {31'd0, mem_rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rden", {31'd0, mem_rd_en}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_maddr", mem_addr, 32'd0);
    chk("mid_rddata", rd_data, 32'd0);
    dc0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_nodone", 32'(done_cnt - dc0), 32'd0);
    v = '{1'b1, 2'd2, 1'b0, 32'h0000_0018, 32'hA5A5C3C3, 32'h0, 2, 1'b0, 32'h0, 32'hA5A5C3C3, 0, 1};
    run_vec(v, "post");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sub_word_mem_ctrl.md
SUB_WORD_MEM_CTRL -- requirements
Module: sub_word_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum MemReady wait cycles per memory phase before an error is flagged.
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Req  input  1  access request from the pipeline; sampled only in IDLE.
REQ-005 Wr  input  1  1 = store, 0 = load.
REQ-006 NumBits  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-007 SignExt  input  1  for loads, 1 = sign-extend and 0 = zero-extend.
REQ-008 Addr  input  32  byte address.
REQ-009 WrData  input  32  store data; sub-word data is right-justified.
REQ-010 Busy  output  1  high whenever state is not IDLE.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 Err  output  1  one-cycle pulse coincident with Done; signals misalignment, reserved size or timeout.
REQ-013 RdData  output  32  load result; valid when Done=1 and held until the next load completes.
REQ-014 MemAddr  output  32  word address to memory, equal to {Addr[31:2],2'b00}.
REQ-015 MemRdEn  output  1  memory read strobe.
REQ-016 MemWrEn  output  1  memory write strobe.
REQ-017 MemWData  output  32  full word written to memory.
REQ-018 MemRData  input  32  memory read data; valid in the cycle MemReady=1.
REQ-019 MemReady  input  1  memory phase-complete handshake.

Function
REQ-020 The FSM SHALL have the states IDLE, RD, MERGE, WR and DONE.
REQ-021 In IDLE with Req=1, the block SHALL capture Wr, NumBits, SignExt, Addr and WrData into internal registers; Req at any other time is ignored.
REQ-022 A request SHALL be treated as an error case when NumBits=3, when NumBits=1 with Addr[0]=1, or when NumBits=2 with Addr[1:0]!=0; error cases go from IDLE to DONE with Err=1 and no memory strobe.
REQ-023 A legal load SHALL go IDLE->RD->DONE.
REQ-024 A legal word store SHALL go IDLE->WR->DONE.
REQ-025 A legal byte or half store SHALL go IDLE->RD->MERGE->WR->DONE (read-modify-write).
REQ-026 MemRdEn SHALL be 1 exactly while in RD; RD exits on the first cycle with MemReady=1.
REQ-027 MemWrEn SHALL be 1 exactly while in WR; WR exits on the first cycle with MemReady=1.
REQ-028 MemAddr SHALL be driven from the captured address during RD and WR, and SHALL be 0 otherwise.
REQ-029 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k], with k = Addr[1:0] for bytes and Addr[1] selecting lanes {1,0} or {3,2} for halves.
REQ-030 Load extraction SHALL happen when MemReady=1 in RD: the selected lane moves to the low bits of RdData, and the upper bits are filled with the sign bit when SignExt=1, else with 0; word loads pass the data unchanged.
REQ-031 MERGE SHALL last one cycle: the block replaces only the selected lane(s) of the latched read word with the low bits of captured WrData, and the result drives MemWData throughout WR.
REQ-032 For word stores, MemWData SHALL equal the captured WrData.
REQ-033 A wait counter SHALL clear on entry to RD or WR and increment each cycle MemReady=0; if it reaches TIMEOUT, the FSM drops the strobe and goes to DONE with Err=1, and RdData is unchanged.
REQ-034 DONE SHALL last exactly one cycle with Done=1, then return to IDLE; a Req in the DONE cycle is ignored.
REQ-035 Minimum latency from the accept edge to the Done cycle, with MemReady=1 in every memory cycle, SHALL be: load 2, word store 2, sub-word store 4, error case 1.

Reset
REQ-036 Asserting Rst_n=0 SHALL immediately (asynchronously) force state IDLE, Busy=Done=Err=0, MemRdEn=MemWrEn=0, MemAddr=MemWData=0, RdData=0 and the wait counter to 0.
REQ-037 A reset in the middle of an operation SHALL abort it with no Done pulse; the first Req after Rst_n returns to 1 is serviced normally.

Verification
REQ-038 Byte load: memory word 0x8899AABB; Req with Wr=0, NumBits=0, Addr=0x...01, SignExt=1 -> RdData=0xFFFFFFAA, Done with Err=0 after 2 cycles.
REQ-039 Half store: memory word 0x11223344; Wr=1, NumBits=1, Addr=0x...02, WrData=0x0000BEEF -> one read, then MemWData=0xBEEF3344 on the single write, Done after 4 cycles.
REQ-040 Misaligned word: Wr=1, NumBits=2, Addr=0x...03 -> Err=Done=1 in the next cycle, with MemRdEn and MemWrEn never asserted.
REQ-041 Timeout: load with MemReady held at 0 -> MemRdEn high for 15 cycles, then Done=Err=1 and RdData unchanged.
REQ-042 Reset in RD: pull Rst_n low while MemRdEn=1 -> MemRdEn=0 and Busy=0 in the same cycle, with no Done; a later word store completes in 2 cycles.
REQ-043 Busy ignore: Req pulsed while Busy=1 -> no new capture, and exactly one Done for the original request.
